// File: rtl/weight_load_scheduler.sv
// rtl/weight_load_scheduler.sv - round-robin burst scheduler sharing one weight ROM port
module weight_load_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 28,
    parameter int LEN_W   = 9,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base_i,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      rom_en_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i,
    output logic [DATA_W-1:0]         wdata_o,
    output logic                      wvalid_o,
    output logic [LEN_W-1:0]          widx_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     offset_q, offset_d;

    // Valid/index pipe tracking addresses in flight through the ROM.
    logic [ROM_LAT-1:0]            vld_q;
    logic [ROM_LAT-1:0][LEN_W-1:0] pidx_q;

    logic [DATA_W-1:0]    wdata_q;
    logic                 wvalid_q;
    logic [LEN_W-1:0]     widx_q;

    logic                 issue;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W:0]       cand_sum;
    logic [PTR_W-1:0]     cand;

    // Round-robin pick: the requester nearest to rr_q (scanning upward, wrapping) wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand       = '0;
        // Scan from farthest to nearest so the nearest set bit is the last assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = cand_sum[PTR_W-1:0];
            if (req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic for the burst FSM and its latched burst descriptor.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        base_d   = base_q;
        len_d    = len_q;
        offset_d = offset_q;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gidx_d   = pick_idx;
                    grant_d  = NUM_REQ'(1) << pick_idx;
                    base_d   = req_base_i[pick_idx*ADDR_W +: ADDR_W];
                    len_d    = req_len_i[pick_idx*LEN_W +: LEN_W];
                    offset_d = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (len_q == '0) begin
                    // Empty burst: complete without touching the ROM.
                    state_d = S_DONE;
                end else begin
                    issue    = 1'b1;
                    offset_d = offset_q + LEN_W'(1);
                    if (offset_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The output register flushes its last word on the same edge the pipe empties.
                if (vld_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d  = '0;
                offset_d = '0;
                rr_d     = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and burst descriptor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            base_q   <= '0;
            len_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            base_q   <= base_d;
            len_q    <= len_d;
            offset_q <= offset_d;
        end
    end

    // Shift issued-address markers alongside the ROM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            pidx_q <= '0;
        end else begin
            vld_q[0]  <= issue;
            pidx_q[0] <= offset_q;
            for (int j = 1; j < ROM_LAT; j++) begin
                vld_q[j]  <= vld_q[j-1];
                pidx_q[j] <= pidx_q[j-1];
            end
        end
    end

    // Register the ROM word with its burst index when the pipe says it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            widx_q   <= '0;
        end else begin
            wvalid_q <= vld_q[ROM_LAT-1];
            if (vld_q[ROM_LAT-1]) begin
                wdata_q <= rom_data_i;
                widx_q  <= pidx_q[ROM_LAT-1];
            end
        end
    end

    assign grant_o    = grant_q;
    assign rom_en_o   = issue;
    assign rom_addr_o = issue ? (base_q + ADDR_W'(offset_q)) : '0;
    assign wdata_o    = wdata_q;
    assign wvalid_o   = wvalid_q;
    assign widx_o     = widx_q;
    assign done_o     = (state_q == S_DONE) ? grant_q : '0;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_weight_load_scheduler.sv
// tb/tb_weight_load_scheduler.sv - self-checking bench for weight_load_scheduler
module tb_weight_load_scheduler;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 28;
    localparam int LW  = 9;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_base;
    logic [N*LW-1:0]   req_len;
    logic [N-1:0]      grant;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [DW-1:0]     wdata;
    logic              wvalid;
    logic [LW-1:0]     widx;
    logic [N-1:0]      done;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int model_rr = 0;
    logic [AW-1:0] base_v [N];
    logic [LW-1:0] len_v  [N];
    logic [DW-1:0] rom_pipe [LAT];

    weight_load_scheduler #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .req_base_i(req_base), .req_len_i(req_len),
        .grant_o(grant), .rom_en_o(rom_en), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .wdata_o(wdata), .wvalid_o(wvalid),
        .widx_o(widx), .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a ^ 8'h5A, ~a, a, a[3:0]};
    endfunction

    // Behavioural synchronous ROM with LAT cycles from address to data.
    always @(posedge clk) begin
        if (rom_en) rom_pipe[0] <= rom_f(rom_addr);
        for (int j = 1; j < LAT; j++) rom_pipe[j] <= rom_pipe[j-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            req_base[i*AW +: AW] = base_v[i];
            req_len[i*LW +: LW]  = len_v[i];
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_rom_en"}, 64'(rom_en), 64'd0);
        chk({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        chk({tag, "_wvalid"}, 64'(wvalid), 64'd0);
        chk({tag, "_widx"}, 64'(widx), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Call at a negedge while the DUT is idle with req already driven.
    // Checks every cycle of the burst plus the idle cycle after done.
    task automatic run_burst(input int mut_at);
        int g, L, T;
        logic [AW-1:0] b, ea;
        logic [LW-1:0] ei;
        logic wv;
        g = rr_pick(req, model_rr);
        chk("owner_exists", 64'(g >= 0), 64'd1);
        if (g < 0) return;
        b = base_v[g];
        L = int'(len_v[g]);
        T = (L == 0) ? 1 : L + LAT + 1;
        for (int c = 0; c <= T + 1; c++) begin
            @(negedge clk);
            chk("grant", 64'(grant), (c <= T) ? (64'(1) << g) : 64'd0);
            chk("busy", 64'(busy), 64'(c <= T));
            chk("rom_en", 64'(rom_en), 64'(c < L));
            if (c < L) begin
                ea = b + AW'(c);
                chk("rom_addr", 64'(rom_addr), 64'(ea));
            end
            wv = (c >= LAT + 1) && (c <= L + LAT);
            chk("wvalid", 64'(wvalid), 64'(wv));
            if (wv) begin
                ei = LW'(c - LAT - 1);
                ea = b + AW'(c - LAT - 1);
                chk("widx", 64'(widx), 64'(ei));
                chk("wdata", 64'(wdata), 64'(rom_f(ea)));
            end
            chk("done", 64'(done), (c == T) ? (64'(1) << g) : 64'd0);
            if (c == mut_at) begin
                req[g]    = 1'b0;
                base_v[g] = AW'($urandom);
                len_v[g]  = LW'($urandom);
                drive_fields();
            end
        end
        model_rr = (g + 1) % N;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            base_v[i] = '0;
            len_v[i]  = '0;
        end
        drive_fields();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        model_rr = 0;

        // Four requesters held high, len 2 each: grants 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            base_v[i] = AW'($urandom);
            len_v[i]  = 2;
        end
        drive_fields();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            chk("rr_order", 64'(rr_pick(req, model_rr)), 64'(n % N));
            run_burst(-1);
        end
        req = '0;
        @(negedge clk);

        // Single requester 0, base 0, len 8.
        base_v[0] = 8'd0;
        len_v[0]  = 9'd8;
        drive_fields();
        req = 4'b0001;
        run_burst(-1);
        req = '0;

        // Address wrap: requester 2 at base 254, len 4.
        base_v[2] = 8'd254;
        len_v[2]  = 9'd4;
        drive_fields();
        req = 4'b0100;
        run_burst(-1);
        req = '0;

        // Zero-length burst on requester 1.
        len_v[1] = 9'd0;
        drive_fields();
        req = 4'b0010;
        run_burst(-1);
        req = '0;

        // Descriptor change and req drop mid-burst are ignored.
        base_v[0] = AW'($urandom);
        len_v[0]  = 9'd12;
        drive_fields();
        req = 4'b0001;
        run_burst(3);
        req = '0;

        // Randomized request vectors and burst descriptors.
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < N; i++) begin
                base_v[i] = AW'($urandom);
                len_v[i]  = LW'($urandom_range(0, 20));
            end
            drive_fields();
            req = N'($urandom_range(1, (1 << N) - 1));
            run_burst(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1);
        end
        req = '0;
        @(negedge clk);

        // Async reset at the 5th word of a 256-word burst.
        base_v[1] = AW'($urandom);
        len_v[1]  = 9'd256;
        drive_fields();
        req = 4'b0010;
        for (int c = 0; c <= LAT + 5; c++) @(negedge clk);
        chk("long_wvalid", 64'(wvalid), 64'd1);
        chk("long_widx", 64'(widx), 64'd4);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) begin
            @(negedge clk);
            chk("midreset_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        model_rr = 0;

        // Clean burst on requester 3 after reset.
        base_v[3] = AW'($urandom);
        len_v[3]  = 9'd6;
        drive_fields();
        req = 4'b1000;
        run_burst(-1);
        req = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
